// File: rtl/alu_ex_stage.sv
// alu_ex_stage: two-stage execute pipeline (S1 operand register feeding the alu, S2 result register to writeback).
// Define ALU_EX_BYPASS_EN to forward from S1/S2 instead of stalling on register hazards.
module alu_ex_stage #(
    parameter int REG_IDX_W    = 5,
    parameter bit R0_HARDWIRED = 1'b1,
    parameter int FUN_W        = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [FUN_W-1:0]     in_fun,
    input  logic [31:0]          in_rs1_val,
    input  logic [31:0]          in_rs2_val,
    input  logic [REG_IDX_W-1:0] in_rs1_idx,
    input  logic [REG_IDX_W-1:0] in_rs2_idx,
    input  logic [31:0]          in_imm,
    input  logic                 in_use_imm,
    input  logic [REG_IDX_W-1:0] in_rd,
    input  logic                 in_rd_we,
    output logic [31:0]          alu_in0,
    output logic [31:0]          alu_in1,
    output logic [FUN_W-1:0]     u_fun,
    input  logic [31:0]          alu_out,
    input  logic                 err_ufun_unk,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_data,
    output logic [REG_IDX_W-1:0] out_rd,
    output logic                 out_rd_we,
    output logic                 out_err,
    output logic                 err_sticky
);
    logic                 s1_v_q, s1_v_d, s1_we_q;
    logic [31:0]          s1_a_q, s1_b_q;
    logic [FUN_W-1:0]     s1_fun_q;
    logic [REG_IDX_W-1:0] s1_rd_q;
    logic                 s2_v_q, s2_v_d, out_we_q, out_err_q, err_sticky_q;
    logic [31:0]          out_data_q;
    logic [REG_IDX_W-1:0] out_rd_q;
    logic                 s2_free, s1_adv, acc, hazard_stall;
    logic                 m1_a, m2_a, m1_b, m2_b;
    logic [31:0]          opa, opb;

    function automatic logic hit(input logic v, input logic we,
                                 input logic [REG_IDX_W-1:0] rd, input logic [REG_IDX_W-1:0] src);
        return v & we & (rd == src) & !(R0_HARDWIRED & (rd == '0));
    endfunction

    always_comb begin
        m1_a = hit(s1_v_q, s1_we_q, s1_rd_q, in_rs1_idx);
        m2_a = hit(s2_v_q, out_we_q, out_rd_q, in_rs1_idx);
        m1_b = !in_use_imm & hit(s1_v_q, s1_we_q, s1_rd_q, in_rs2_idx);
        m2_b = !in_use_imm & hit(s2_v_q, out_we_q, out_rd_q, in_rs2_idx);
`ifdef ALU_EX_BYPASS_EN
        // S1 is the newest producer, so it wins over S2
        hazard_stall = 1'b0;
        opa = m1_a ? alu_out : m2_a ? out_data_q : in_rs1_val;
        opb = in_use_imm ? in_imm : m1_b ? alu_out : m2_b ? out_data_q : in_rs2_val;
`else
        hazard_stall = m1_a | m2_a | m1_b | m2_b;
        opa = in_rs1_val;
        opb = in_use_imm ? in_imm : in_rs2_val;
`endif
        s2_free  = !s2_v_q | out_ready;
        s1_adv   = s1_v_q & s2_free;
        in_ready = !flush & (!s1_v_q | s1_adv) & !hazard_stall;
        acc      = in_valid & in_ready;
        s1_v_d   = flush ? 1'b0 : acc ? 1'b1 : s1_adv ? 1'b0 : s1_v_q;
        s2_v_d   = flush ? 1'b0 : s1_adv ? 1'b1 : out_ready ? 1'b0 : s2_v_q;
    end

    always_ff @(posedge clk) begin
        if (acc) begin
            s1_a_q   <= opa;
            s1_b_q   <= opb;
            s1_fun_q <= in_fun;
            s1_rd_q  <= in_rd;
            s1_we_q  <= in_rd_we & !(R0_HARDWIRED & (in_rd == '0));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q       <= 1'b0;
            s2_v_q       <= 1'b0;
            out_data_q   <= '0;
            out_rd_q     <= '0;
            out_we_q     <= 1'b0;
            out_err_q    <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            s1_v_q       <= s1_v_d;
            s2_v_q       <= s2_v_d;
            err_sticky_q <= err_sticky_q | (err_ufun_unk & s1_adv);
            if (s1_adv) begin
                out_data_q <= alu_out;
                out_rd_q   <= s1_rd_q;
                out_we_q   <= s1_we_q;
                out_err_q  <= err_ufun_unk;
            end
        end
    end

    assign alu_in0    = s1_a_q;
    assign alu_in1    = s1_b_q;
    assign u_fun      = s1_fun_q;
    assign out_valid  = s2_v_q;
    assign out_data   = out_data_q;
    assign out_rd     = out_rd_q;
    assign out_rd_we  = out_we_q;
    assign out_err    = out_err_q;
    assign err_sticky = err_sticky_q;
endmodule

// File: tb/tb_alu_ex_stage.sv
// tb_alu_ex_stage: directed bench for alu_ex_stage with a small behavioural alu attached.
module tb_alu_ex_stage;
    localparam logic [3:0] ADD = 4'h0, SUB = 4'h1, AND_ = 4'h2, BAD = 4'hF;

    logic        clk = 1'b0, rst, flush, in_valid, in_ready, in_use_imm, in_rd_we;
    logic [3:0]  in_fun, u_fun;
    logic [31:0] in_rs1_val, in_rs2_val, in_imm, alu_in0, alu_in1, alu_out, out_data;
    logic [4:0]  in_rs1_idx, in_rs2_idx, in_rd, out_rd;
    logic        err_ufun_unk, out_valid, out_ready, out_rd_we, out_err, err_sticky;
    int          errors = 0, checks = 0;

    always #5 clk = ~clk;

    assign alu_out      = u_fun == ADD ? alu_in0 + alu_in1 : u_fun == SUB ? alu_in0 - alu_in1 :
                          u_fun == AND_ ? alu_in0 & alu_in1 : 32'd0;
    assign err_ufun_unk = !(u_fun == ADD || u_fun == SUB || u_fun == AND_);

    alu_ex_stage dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_fun(in_fun), .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
        .in_rs1_idx(in_rs1_idx), .in_rs2_idx(in_rs2_idx), .in_imm(in_imm),
        .in_use_imm(in_use_imm), .in_rd(in_rd), .in_rd_we(in_rd_we),
        .alu_in0(alu_in0), .alu_in1(alu_in1), .u_fun(u_fun), .alu_out(alu_out),
        .err_ufun_unk(err_ufun_unk), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_rd(out_rd), .out_rd_we(out_rd_we), .out_err(out_err),
        .err_sticky(err_sticky)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic op(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        in_valid   = 1'b1;
        in_fun     = f;
        in_rs1_val = a;
        in_rs2_val = b;
        in_rs1_idx = 5'd1;
        in_rs2_idx = 5'd2;
        in_imm     = 32'd0;
        in_use_imm = 1'b0;
        in_rd      = rd;
        in_rd_we   = 1'b1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        op(ADD, 0, 0, 0);
        in_valid = 1'b0;
        tick; tick;
        rst = 1'b0;
        tick;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_err_sticky", err_sticky, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_rd_we", out_rd_we, 0);

        op(ADD, 5, 7, 3);
        #1 chk("add_ready", in_ready, 1);
        tick;
        in_valid = 1'b0;
        chk("add_alu_in0", alu_in0, 5);
        chk("add_alu_in1", alu_in1, 7);
        chk("add_k1_valid", out_valid, 0);
        tick;
        chk("add_valid", out_valid, 1);
        chk("add_data", out_data, 12);
        chk("add_rd", out_rd, 3);
        chk("add_rd_we", out_rd_we, 1);
        chk("add_err", out_err, 0);
        tick;
        chk("add_drained", out_valid, 0);

        op(ADD, 5, 7, 3);
        tick;
        op(SUB, 0, 0, 4);
        in_rs1_idx = 5'd3; in_rs2_idx = 5'd9; in_imm = 32'd2; in_use_imm = 1'b1;
`ifdef ALU_EX_BYPASS_EN
        #1 chk("dep_ready", in_ready, 1);
        tick;
        in_valid = 1'b0;
        chk("dep_first", out_data, 12);
        chk("dep_first_v", out_valid, 1);
        tick;
        chk("dep_second", out_data, 10);
        chk("dep_second_v", out_valid, 1);
        tick;
`else
        #1 chk("dep_stall_s1", in_ready, 0);
        tick;
        chk("dep_first", out_data, 12);
        chk("dep_first_v", out_valid, 1);
        chk("dep_stall_s2", in_ready, 0);
        tick;
        in_rs1_val = 32'd12;
        #1 chk("dep_ready", in_ready, 1);
        tick;
        in_valid = 1'b0;
        tick;
        chk("dep_second", out_data, 10);
        chk("dep_second_v", out_valid, 1);
        tick;
`endif
        chk("dep_drained", out_valid, 0);

        out_ready = 1'b0;
        op(ADD, 1, 2, 5);
        in_rs1_idx = 5'd10; in_rs2_idx = 5'd11;
        #1 chk("bp_acc_a", in_ready, 1);
        tick;
        op(ADD, 10, 20, 6);
        in_rs1_idx = 5'd10; in_rs2_idx = 5'd11;
        #1 chk("bp_acc_b", in_ready, 1);
        tick;
        op(ADD, 100, 200, 7);
        in_rs1_idx = 5'd10; in_rs2_idx = 5'd11;
        #1 chk("bp_full", in_ready, 0);
        tick;
        chk("bp_hold_ready", in_ready, 0);
        chk("bp_data_a", out_data, 3);
        tick;
        chk("bp_stable", out_data, 3);
        chk("bp_stable_rd", out_rd, 5);
        out_ready = 1'b1;
        #1 chk("bp_release_ready", in_ready, 1);
        tick;
        in_valid = 1'b0;
        chk("bp_data_b", out_data, 30);
        tick;
        chk("bp_data_c", out_data, 300);
        chk("bp_rd_c", out_rd, 7);
        tick;
        chk("bp_drained", out_valid, 0);

        op(BAD, 3, 4, 8);
        tick;
        op(ADD, 6, 7, 9);
        tick;
        in_valid = 1'b0;
        chk("unk_valid", out_valid, 1);
        chk("unk_err", out_err, 1);
        chk("unk_data", out_data, 0);
        chk("unk_sticky", err_sticky, 1);
        tick;
        chk("unk_next_data", out_data, 13);
        chk("unk_next_err", out_err, 0);
        chk("unk_sticky_hold", err_sticky, 1);
        tick;

        out_ready = 1'b0;
        op(ADD, 5, 5, 10);
        tick;
        op(ADD, 6, 6, 11);
        tick;
        op(ADD, 7, 7, 12);
        flush = 1'b1;
        #1 chk("flush_ready", in_ready, 0);
        tick;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("flush_no_out", out_valid, 0);
            tick;
        end

        op(ADD, 1, 2, 0);
        tick;
        op(ADD, 40, 0, 12);
        in_rs1_idx = 5'd0; in_rs2_idx = 5'd0; in_imm = 32'd2; in_use_imm = 1'b1;
        #1 chk("r0_no_stall", in_ready, 1);
        tick;
        in_valid = 1'b0;
        chk("r0_prod_data", out_data, 3);
        chk("r0_prod_we", out_rd_we, 0);
        tick;
        chk("r0_cons_data", out_data, 42);
        chk("r0_cons_rd", out_rd, 12);
        tick;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
